// File: rtl/pline_hazard_ctrl.sv
// Stall/flush sequencer for the MicroEV20 4-stage pipeline (mispredict, load-use, dmem busy).
// Optional performance counters are enabled with `define PLINE_PERF_CNT_EN.
module pline_hazard_ctrl #(
    parameter int REG_ADDR_W        = 4,
    parameter int FLUSH_CYCLES      = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  incorrect_pred,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic                  exec_valid,
    input  logic                  exec_is_load,
    input  logic [REG_ADDR_W-1:0] exec_rd,
    input  logic                  mem_busy,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_bubble,
    output logic                  ex_stall,
    output logic                  exec_ignore,
    output logic                  wrtback_ignore,
    output logic                  mem_timeout,
    output logic                  busy
`ifdef PLINE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    localparam int M1   = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
    localparam int CMAX = (M1 > MEM_TIMEOUT) ? M1 : MEM_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {RUN, FLUSH, LOAD_STALL, MEM_STALL} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            xi_nxt, wi_nxt, to_nxt;
    logic            flush_take, ld_take;
    logic            load_hz, mem_eff;

    assign load_hz = exec_valid & exec_is_load & (exec_rd != '0) &
                     ((dec_rs1_used & (dec_rs1 == exec_rd)) |
                      (dec_rs2_used & (dec_rs2 == exec_rd)));

    // The cycle right after a timeout ignores mem_busy so the stalls really release.
    assign mem_eff = mem_busy & ~mem_timeout;

    assign busy = (state != RUN);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        xi_nxt       = exec_ignore;
        wi_nxt       = wrtback_ignore;
        to_nxt       = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_stall     = 1'b0;
        flush_take   = 1'b0;
        ld_take      = 1'b0;
        case (state)
            RUN, LOAD_STALL: begin
                if (incorrect_pred) begin
                    flush_take = 1'b1;
                end else if (mem_eff) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    ex_stall    = 1'b1;
                    state_nxt   = MEM_STALL;
                    cnt_nxt     = CW'(MEM_TIMEOUT);
                end else if (state == LOAD_STALL) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (cnt <= CW'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end else if (load_hz) begin
                    ld_take = 1'b1;
                end
            end
            FLUSH: begin
                if (incorrect_pred) begin
                    flush_take = 1'b1;
                end else begin
                    if (cnt == CW'(1)) xi_nxt = 1'b0;
                    if (cnt == '0) begin
                        wi_nxt    = 1'b0;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            end
            MEM_STALL: begin
                // Exec is frozen here, so a mispredict cannot legally arrive; it is ignored.
                if (mem_busy) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    ex_stall    = 1'b1;
                    if (cnt == '0) begin
                        to_nxt    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end else begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    ld_take   = load_hz;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase

        if (flush_take) begin
            state_nxt = FLUSH;
            cnt_nxt   = CW'(FLUSH_CYCLES);
            xi_nxt    = 1'b1;
            wi_nxt    = 1'b1;
        end

        // Load-use stall is asserted in the same cycle the hazard is seen.
        if (ld_take) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nxt = LOAD_STALL;
                cnt_nxt   = CW'(LOAD_STALL_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            cnt            <= '0;
            exec_ignore    <= 1'b0;
            wrtback_ignore <= 1'b0;
            mem_timeout    <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            exec_ignore    <= xi_nxt;
            wrtback_ignore <= wi_nxt;
            mem_timeout    <= to_nxt;
        end
    end

`ifdef PLINE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_take && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pline_hazard_ctrl.sv
// Bench for pline_hazard_ctrl: vector table plus hand sequences on two parameterizations.
module tb_pline_hazard_ctrl;

    typedef struct packed {
        logic       ip;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       ev;
        logic       el;
        logic [3:0] rd;
        logic       mb;
    } inp_t;

    typedef struct {
        inp_t       i;
        logic [7:0] e;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       incorrect_pred = 1'b0;
    logic [3:0] dec_rs1 = '0, dec_rs2 = '0, exec_rd = '0;
    logic       dec_rs1_used = 1'b0, dec_rs2_used = 1'b0;
    logic       exec_valid = 1'b0, exec_is_load = 1'b0, mem_busy = 1'b0;

    logic pc1, ifid1, bub1, ex1, xi1, wi1, to1, busy1;
    logic pc2, ifid2, bub2, ex2, xi2, wi2, to2, busy2;
    logic [7:0] o1, o2;
`ifdef PLINE_PERF_CNT_EN
    logic [15:0] fcnt1, scnt1, fcnt2, scnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    pline_hazard_ctrl #(.REG_ADDR_W(4), .FLUSH_CYCLES(4), .LOAD_STALL_CYCLES(1),
                        .MEM_TIMEOUT(255), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .incorrect_pred(incorrect_pred),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_used(dec_rs2_used), .exec_valid(exec_valid), .exec_is_load(exec_is_load),
        .exec_rd(exec_rd), .mem_busy(mem_busy),
        .pc_stall(pc1), .if_id_stall(ifid1), .id_ex_bubble(bub1), .ex_stall(ex1),
        .exec_ignore(xi1), .wrtback_ignore(wi1), .mem_timeout(to1), .busy(busy1)
`ifdef PLINE_PERF_CNT_EN
        , .flush_cnt(fcnt1), .stall_cnt(scnt1)
`endif
    );

    pline_hazard_ctrl #(.REG_ADDR_W(4), .FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(2),
                        .MEM_TIMEOUT(3), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .incorrect_pred(incorrect_pred),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_used(dec_rs2_used), .exec_valid(exec_valid), .exec_is_load(exec_is_load),
        .exec_rd(exec_rd), .mem_busy(mem_busy),
        .pc_stall(pc2), .if_id_stall(ifid2), .id_ex_bubble(bub2), .ex_stall(ex2),
        .exec_ignore(xi2), .wrtback_ignore(wi2), .mem_timeout(to2), .busy(busy2)
`ifdef PLINE_PERF_CNT_EN
        , .flush_cnt(fcnt2), .stall_cnt(scnt2)
`endif
    );

    // [7]pc [6]if_id [5]bubble [4]ex [3]exec_ign [2]wb_ign [1]timeout [0]busy
    assign o1 = {pc1, ifid1, bub1, ex1, xi1, wi1, to1, busy1};
    assign o2 = {pc2, ifid2, bub2, ex2, xi2, wi2, to2, busy2};

    // A mispredict while exec is frozen is illegal stimulus.
    always @(posedge clk)
        if (!rst) assert (!(incorrect_pred && (ex1 || ex2)))
            else $error("illegal incorrect_pred while exec frozen");

    function automatic inp_t mk(logic ip, logic [3:0] rs1, logic [3:0] rs2, logic u1,
                                logic u2, logic ev, logic el, logic [3:0] rd, logic mb);
        inp_t r;
        r.ip = ip; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.ev = ev; r.el = el; r.rd = rd; r.mb = mb;
        return r;
    endfunction

    task automatic apply(input inp_t i);
        incorrect_pred = i.ip;
        dec_rs1 = i.rs1; dec_rs2 = i.rs2;
        dec_rs1_used = i.u1; dec_rs2_used = i.u2;
        exec_valid = i.ev; exec_is_load = i.el;
        exec_rd = i.rd; mem_busy = i.mb;
    endtask

    // Drive one cycle, queue its expectation, compare mid-cycle.
    task automatic cyc(input bit sel, input inp_t i, input logic [7:0] e, input string nm);
        logic [7:0] got, want;
        string      n;
        apply(i);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        got  = sel ? o2 : o1;
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", n, got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic drive(input inp_t i, input int n);
        for (int k = 0; k < n; k++) begin
            apply(i);
            @(posedge clk); #1;
        end
    endtask

    vec_t vt[8];
    inp_t IDLE, HZ, IP, MB, MBHZ, IPHZ;

    initial begin
        IDLE = '0;
        HZ   = mk(0, 4'd0, 4'd3, 0, 1, 1, 1, 4'd3, 0);
        IP   = mk(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0);
        MB   = mk(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1);
        MBHZ = mk(0, 4'd0, 4'd3, 0, 1, 1, 1, 4'd3, 1);
        IPHZ = mk(1, 4'd0, 4'd3, 0, 1, 1, 1, 4'd3, 0);

        vt[0] = '{IDLE, 8'h00, "run_idle"};
        vt[1] = '{HZ, 8'hE0, "ld_rs2_r3"};
        vt[2] = '{IDLE, 8'h00, "ld_one_cycle"};
        vt[3] = '{mk(0, 4'd0, 4'd0, 0, 1, 1, 1, 4'd0, 0), 8'h00, "ld_rd0"};
        vt[4] = '{mk(0, 4'd5, 4'd0, 0, 0, 1, 1, 4'd5, 0), 8'h00, "ld_rs1_unused"};
        vt[5] = '{mk(0, 4'd5, 4'd0, 1, 0, 1, 1, 4'd5, 0), 8'hE0, "ld_rs1_used"};
        vt[6] = '{mk(0, 4'd5, 4'd0, 1, 0, 0, 1, 4'd5, 0), 8'h00, "ld_not_valid"};
        vt[7] = '{mk(0, 4'd5, 4'd0, 1, 0, 1, 0, 4'd5, 0), 8'h00, "not_load"};

        apply(IDLE);
        repeat (2) @(posedge clk);
        #1;
        cyc(0, IDLE, 8'h00, "reset1");
        cyc(1, IDLE, 8'h00, "reset2");
        rst = 1'b0;

        for (int k = 0; k < 8; k++) cyc(0, vt[k].i, vt[k].e, vt[k].name);

        // single flush
        cyc(0, IP, 8'h00, "fl_pulse");
        for (int k = 0; k < 4; k++) cyc(0, IDLE, 8'h0D, "fl_both");
        cyc(0, IDLE, 8'h05, "fl_wb_only");
        cyc(0, IDLE, 8'h00, "fl_done");

        // restart during flush
        cyc(0, IP, 8'h00, "rs_pulse");
        cyc(0, IDLE, 8'h0D, "rs_a");
        cyc(0, IP, 8'h0D, "rs_pulse2");
        for (int k = 0; k < 4; k++) cyc(0, IDLE, 8'h0D, "rs_both");
        cyc(0, IDLE, 8'h05, "rs_wb_only");
        cyc(0, IDLE, 8'h00, "rs_done");

        // mispredict beats load hazard
        cyc(0, IPHZ, 8'h00, "iphz_no_bubble");
        for (int k = 0; k < 4; k++) cyc(0, IDLE, 8'h0D, "iphz_both");
        cyc(0, IDLE, 8'h05, "iphz_wb");
        cyc(0, IDLE, 8'h00, "iphz_done");

        // reset mid-flush
        cyc(0, IP, 8'h00, "rf_pulse");
        cyc(0, IDLE, 8'h0D, "rf_a");
        rst = 1'b1;
        cyc(0, IDLE, 8'h0D, "rf_rst_cycle");
        rst = 1'b0;
        cyc(0, IDLE, 8'h00, "rf_cleared");

        // memory busy for 5 cycles
        cyc(0, MB, 8'hD0, "mb_entry");
        for (int k = 0; k < 4; k++) cyc(0, MB, 8'hD1, "mb_hold");
        cyc(0, IDLE, 8'h01, "mb_release");
        cyc(0, IDLE, 8'h00, "mb_run");

        // mem busy beats load hazard; hazard re-evaluated on release
        cyc(0, MBHZ, 8'hD0, "mbhz_entry");
        cyc(0, MBHZ, 8'hD1, "mbhz_hold");
        cyc(0, HZ, 8'hE1, "mbhz_reeval");
        cyc(0, IDLE, 8'h00, "mbhz_run");

        rst = 1'b1;
        drive(IDLE, 1);
        rst = 1'b0;

        // second config: two-cycle load stall, timeout 3, flush 2
        cyc(1, HZ, 8'hE0, "l2_first");
        cyc(1, IDLE, 8'hE1, "l2_second");
        cyc(1, IDLE, 8'h00, "l2_done");
        cyc(1, MB, 8'hD0, "to_entry");
        for (int k = 0; k < 4; k++) cyc(1, MB, 8'hD1, "to_hold");
        cyc(1, MB, 8'h02, "to_pulse");
        cyc(1, IDLE, 8'h00, "to_clear");
        cyc(1, IP, 8'h00, "f2_pulse");
        cyc(1, IDLE, 8'h0D, "f2_a");
        cyc(1, IDLE, 8'h0D, "f2_b");
        cyc(1, IDLE, 8'h05, "f2_wb");
        cyc(1, IDLE, 8'h00, "f2_done");

`ifdef PLINE_PERF_CNT_EN
        rst = 1'b1;
        drive(IDLE, 1);
        rst = 1'b0;
        drive(IP, 1);
        drive(IDLE, 6);
        drive(IP, 1);
        drive(IDLE, 6);
        drive(MB, 3);
        drive(IDLE, 2);
        n_tests++;
        if (fcnt1 !== 16'd2) begin
            n_fail++;
            $display("FAIL flush_cnt: got %0d want 2", fcnt1);
        end
        n_tests++;
        if (scnt1 !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d want 3", scnt1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pline_hazard_ctrl.md
Name: pline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the MicroEV20 4-stage pipeline (fetch, decode, exec, writeback).
- Merges three hazard sources into one coherent set of stage-control signals: branch mispredict from exec, load-use dependency between decode and exec, and data-memory busy.
- Supersedes standalone flush control: owns exec_ignore/wrtback_ignore plus the PC, IF/ID and ID/EX stall/bubble controls.

Parameters:
REG_ADDR_W, 4, register-index width
FLUSH_CYCLES, 4, cycles exec_ignore stays high after a mispredict (>=1)
LOAD_STALL_CYCLES, 1, decode stall cycles per load-use hazard (>=1)
MEM_TIMEOUT, 255, max consecutive mem_busy cycles before mem_timeout fires
CNT_W, 16, width of performance counters (optional feature)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
incorrect_pred  in  1  exec-stage mispredict, single-cycle pulse
dec_rs1  in  REG_ADDR_W  decode source register 1
dec_rs2  in  REG_ADDR_W  decode source register 2
dec_rs1_used  in  1  rs1 is read by the decode instruction
dec_rs2_used  in  1  rs2 is read by the decode instruction
exec_valid  in  1  exec stage holds a live instruction
exec_is_load  in  1  exec instruction is a load
exec_rd  in  REG_ADDR_W  exec destination register
mem_busy  in  1  data memory not ready
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
id_ex_bubble  out  1  insert NOP into ID/EX
ex_stall  out  1  freeze exec and writeback registers
exec_ignore  out  1  suppress exec-stage side effects
wrtback_ignore  out  1  suppress register-file write
mem_timeout  out  1  one-cycle pulse on memory timeout
busy  out  1  state != RUN

Behaviour:
- States: RUN, FLUSH, LOAD_STALL, MEM_STALL; 2-bit state register plus a down-counter cnt (width fits max of the parameters).
- Reset (rst=1 at a clock edge): state=RUN, cnt=0; exec_ignore=0, wrtback_ignore=0, mem_timeout=0. All combinational outputs read 0 in RUN with no hazard.
- load_hz (combinational) = exec_valid & exec_is_load & (exec_rd!=0) & ((dec_rs1_used & dec_rs1==exec_rd) | (dec_rs2_used & dec_rs2==exec_rd)).
- Transition priority from RUN, LOAD_STALL: incorrect_pred > mem_busy > load_hz.
- FLUSH: entered on an edge with incorrect_pred=1 from RUN, LOAD_STALL or FLUSH (restart). At entry exec_ignore=1, wrtback_ignore=1, cnt=FLUSH_CYCLES. Each later edge: cnt-=1. At the edge where cnt==1, exec_ignore->0. At the edge where cnt==0, wrtback_ignore->0 and state->RUN. Net effect: exec_ignore high FLUSH_CYCLES cycles, wrtback_ignore high FLUSH_CYCLES+1 cycles. load_hz is ignored in FLUSH.
- Load-use, combinational and same cycle: in RUN with load_hz=1 and no higher-priority event, pc_stall=if_id_stall=id_ex_bubble=1. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1; the three outputs stay high; cnt decrements each edge; at cnt==1, return to RUN.
- MEM_STALL: entered from RUN/LOAD_STALL when mem_busy=1, cnt=MEM_TIMEOUT. While there, pc_stall=if_id_stall=ex_stall=1 and id_ex_bubble=0, driven combinationally from mem_busy so the deassert is same-cycle. At the edge where mem_busy=0, return to RUN; a pending load stall is re-evaluated from live inputs. cnt decrements while busy. At cnt==0 with mem_busy still 1, mem_timeout pulses for 1 cycle, the state is forced to RUN and stalls release.
- incorrect_pred in MEM_STALL is illegal (exec is frozen); it is ignored and is a bench assertion.
- rst mid-FLUSH/STALL: immediate return to the reset values at that edge.

Optional Feature:
PLINE_PERF_CNT_EN:
- Defined: adds output ports flush_cnt[CNT_W] (increments on each FLUSH entry, including restarts) and stall_cnt[CNT_W] (increments each cycle pc_stall=1). Both saturate at all-ones and clear on rst.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Mispredict pulse at cycle 10, FLUSH_CYCLES=4 -> exec_ignore high cycles 10-13, wrtback_ignore high cycles 10-14, busy low from cycle 15.
- Second mispredict at cycle 12 during the flush -> counter restarts; exec_ignore high until cycle 15, wrtback_ignore until cycle 16.
- exec load to r3, decode reads r3 via rs2 -> pc_stall/if_id_stall/id_ex_bubble high exactly 1 cycle; same case with exec_rd=0 -> no stall.
- mem_busy high 5 cycles -> pc_stall/if_id_stall/ex_stall high those 5 cycles, then RUN; MEM_TIMEOUT=3 with mem_busy held -> mem_timeout pulse 4 cycles after entry, stalls released.
- Mispredict and load_hz in the same cycle -> FLUSH entered, no id_ex_bubble; rst asserted mid-FLUSH -> all outputs 0 on the next edge.
- With PLINE_PERF_CNT_EN: 2 flushes plus a 3-cycle mem stall -> flush_cnt=2, stall_cnt=3.
